qracc_psum_accumulator: RTL

//   Downstream of qr_acc_wrapper: consumes per-column signed ADC codes (adc_out_o), one per input bit plane.

---
 rtl/qracc_psum_accumulator.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/qracc_psum_accumulator.sv
// Bit-plane shift-accumulator: folds MSB-first signed ADC codes into saturating
// per-column partial sums and delivers each finished batch on a valid/ready port.
module qracc_psum_accumulator #(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int numCfgBits = 8,
    parameter int accBits    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numCfgBits-1:0]          n_input_bits_cfg,
    input  logic                           signed_cfg,
    input  logic                           adc_valid_i,
    output logic                           adc_ready_o,
    input  logic [numCols*numAdcBits-1:0]  adc_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [numCols*accBits-1:0]     out_data_o,
    output logic [numCols-1:0]             out_sat_o
);

    localparam int WW = accBits + 2;
    localparam logic signed [WW-1:0] ACC_MAX = {3'b000, {(accBits-1){1'b1}}};
    localparam logic signed [WW-1:0] ACC_MIN = {3'b111, {(accBits-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t                      state_q, state_d;
    logic                        adc_ready_q, adc_ready_d;
    logic [numCfgBits-1:0]       plane_cnt_q, plane_cnt_d;
    logic [numCfgBits-1:0]       n_bits_q, n_bits_d;
    logic                        signed_q, signed_d;
    logic signed [accBits-1:0]   acc_q [numCols];
    logic signed [accBits-1:0]   acc_d [numCols];
    logic [numCols-1:0]          sat_q, sat_d;
    logic                        out_valid_q, out_valid_d;
    logic [accBits-1:0]          out_data_q [numCols];
    logic [accBits-1:0]          out_data_d [numCols];
    logic [numCols-1:0]          out_sat_q, out_sat_d;

    logic                        accept;
    logic                        out_fire;
    logic                        plane0;
    logic                        last_plane;
    logic                        signed_eff;
    logic [numCfgBits-1:0]       cfg_n;
    logic [numCfgBits-1:0]       n_eff;
    logic signed [WW-1:0]        a_ext [numCols];
    logic signed [WW-1:0]        wide  [numCols];
    logic signed [accBits-1:0]   acc_step [numCols];
    logic [numCols-1:0]          sat_step;

    assign accept     = adc_valid_i && adc_ready_q;
    assign out_fire   = out_valid_q && out_ready_i;
    assign plane0     = (plane_cnt_q == '0);
    assign cfg_n      = (n_input_bits_cfg == '0) ? numCfgBits'(1) : n_input_bits_cfg;
    assign n_eff      = plane0 ? cfg_n : n_bits_q;
    assign signed_eff = plane0 ? signed_cfg : signed_q;
    assign last_plane = (plane_cnt_q == n_eff - numCfgBits'(1));

    // Per-lane step; the code is sign-extended before negation so -2^(numAdcBits-1) is safe.
    always_comb begin
        for (int unsigned k = 0; k < numCols; k++) begin
            a_ext[k] = {{(WW-numAdcBits){adc_data_i[k*numAdcBits + numAdcBits - 1]}},
                        adc_data_i[k*numAdcBits +: numAdcBits]};
            if (plane0) begin
                wide[k] = signed_eff ? -a_ext[k] : a_ext[k];
            end else begin
                wide[k] = {acc_q[k][accBits-1], acc_q[k], 1'b0} + a_ext[k];
            end
            if (wide[k] > ACC_MAX) begin
                acc_step[k] = ACC_MAX[accBits-1:0];
                sat_step[k] = 1'b1;
            end else if (wide[k] < ACC_MIN) begin
                acc_step[k] = ACC_MIN[accBits-1:0];
                sat_step[k] = 1'b1;
            end else begin
                acc_step[k] = wide[k][accBits-1:0];
                sat_step[k] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        adc_ready_d = adc_ready_q;
        plane_cnt_d = plane_cnt_q;
        n_bits_d    = n_bits_q;
        signed_d    = signed_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (plane0) begin
                        n_bits_d = cfg_n;
                        signed_d = signed_cfg;
                    end
                    acc_d       = acc_step;
                    sat_d       = plane0 ? sat_step : (sat_q | sat_step);
                    plane_cnt_d = last_plane ? '0 : plane_cnt_q + numCfgBits'(1);
                    if (last_plane) begin
                        if (!out_valid_q || out_ready_i) begin
                            for (int unsigned k = 0; k < numCols; k++) begin
                                out_data_d[k] = acc_step[k];
                            end
                            out_sat_d   = plane0 ? sat_step : (sat_q | sat_step);
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = ST_HOLD;
                            adc_ready_d = 1'b0;
                        end
                    end
                end
            end
            ST_HOLD: begin
                // Finished batch waits in acc_q until the presented one is taken.
                if (out_fire) begin
                    for (int unsigned k = 0; k < numCols; k++) begin
                        out_data_d[k] = acc_q[k];
                    end
                    out_sat_d   = sat_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_ACC;
                    adc_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_ACC;
                adc_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            adc_ready_q <= 1'b1;
            plane_cnt_q <= '0;
            n_bits_q    <= numCfgBits'(1);
            signed_q    <= 1'b0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= '0;
            for (int unsigned k = 0; k < numCols; k++) begin
                acc_q[k]      <= '0;
                out_data_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            adc_ready_q <= adc_ready_d;
            plane_cnt_q <= plane_cnt_d;
            n_bits_q    <= n_bits_d;
            signed_q    <= signed_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            for (int unsigned k = 0; k < numCols; k++) begin
                acc_q[k]      <= acc_d[k];
                out_data_q[k] <= out_data_d[k];
            end
        end
    end

    always_comb begin
        out_data_o = '0;
        for (int unsigned k = 0; k < numCols; k++) begin
            out_data_o[k*accBits +: accBits] = out_data_q[k];
        end
    end

    assign adc_ready_o = adc_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sat_o   = out_sat_q;

endmodule
